mag_compare_arbiter: RTL and testbench

MAG_COMPARE_ARBITER -- requirements
Module: mag_compare_arbiter

---
 rtl/mag_compare_arbiter.sv | 140 ++++++++++++++
 tb/tb_mag_compare_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_compare_arbiter.sv
// Two-requester arbiter feeding a bit-serial, MSB-first unsigned magnitude comparator.
// One operand pair is examined at a time; the result is latched and held until the next compare.
module mag_compare_arbiter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic             res_lt,
    output logic             res_eq,
    output logic             res_gt,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [IW-1:0]     idx_q;
    logic              id_q;
    logic              last_grant_q;
    logic              res_id_q, res_lt_q, res_eq_q, res_gt_q;

    logic grant_sel;
    logic accept;
    logic a_bit, b_bit, lt_bit, gt_bit, last_bit;

    assign a_bit    = a_q[idx_q];
    assign b_bit    = b_q[idx_q];
    assign lt_bit   = ~a_bit & b_bit;
    assign gt_bit   = a_bit & ~b_bit;
    assign last_bit = (idx_q == '0);

    // On contention the requester that did not win last time is served.
    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant_q;
        end else if (req1_valid) begin
            grant_sel = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_SCAN;
            ST_SCAN: if (lt_bit || gt_bit || last_bit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        res_valid  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (!reset) begin
                    req0_ready = req0_valid & ~grant_sel;
                    req1_ready = req1_valid & grant_sel;
                end
            end
            ST_DONE: res_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = req0_ready | req1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            res_id_q     <= 1'b0;
            res_lt_q     <= 1'b0;
            res_eq_q     <= 1'b0;
            res_gt_q     <= 1'b0;
        end else begin
            if (accept) begin
                a_q          <= grant_sel ? req1_a : req0_a;
                b_q          <= grant_sel ? req1_b : req0_b;
                id_q         <= grant_sel;
                idx_q        <= IDX_MSB;
                last_grant_q <= grant_sel;
            end
            if (state_q == ST_SCAN) begin
                if (lt_bit || gt_bit) begin
                    res_id_q <= id_q;
                    res_lt_q <= lt_bit;
                    res_gt_q <= gt_bit;
                    res_eq_q <= 1'b0;
                end else if (last_bit) begin
                    res_id_q <= id_q;
                    res_lt_q <= 1'b0;
                    res_gt_q <= 1'b0;
                    res_eq_q <= 1'b1;
                end else begin
                    idx_q <= idx_q - 1'b1;
                end
            end
        end
    end

    assign res_id = res_id_q;
    assign res_lt = res_lt_q;
    assign res_eq = res_eq_q;
    assign res_gt = res_gt_q;

endmodule

// File: tb/tb_mag_compare_arbiter.sv
// Scoreboard bench for mag_compare_arbiter: expected results are queued at accept time
// and compared by a negedge monitor in the cycle the result is due.
module tb_mag_compare_arbiter;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_id, res_lt, res_eq, res_gt, busy;

    mag_compare_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_lt     (res_lt),
        .res_eq     (res_eq),
        .res_gt     (res_gt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit id;
        bit lt;
        bit eq;
        bit gt;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t predict(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input int acc_edge);
        exp_t e;
        int   k;
        k = W;
        for (int i = W - 1; i >= 0; i--) begin
            if (a[i] != b[i]) begin
                k = W - i;
                break;
            end
        end
        e.due = acc_edge + k;
        e.id  = who;
        e.lt  = (a < b);
        e.eq  = (a == b);
        e.gt  = (a > b);
        return e;
    endfunction

    // Result monitor plus ready-legality checks.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            exp_t e;
            e = sbq.pop_front();
            chk("res_valid_due", res_valid, 1);
            chk("res_id", res_id, e.id);
            chk("res_flags", {res_lt, res_eq, res_gt}, {e.lt, e.eq, e.gt});
        end else if (res_valid) begin
            chk("res_spurious", res_valid, 0);
        end
        if (busy) chk("ready_in_busy", {req0_ready, req1_ready}, 0);
        if (reset) chk("ready_in_reset", {req0_ready, req1_ready}, 0);
    end

    task automatic issue(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int acc_edge);
        bit got;
        got = 1'b0;
        acc_edge = -1;
        @(posedge clk);
        #1;
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if ((who ? req1_ready : req0_ready) == 1'b1) begin
                got = 1'b1;
                acc_edge = cyc + 1;
                chk("ready_excl", req0_ready & req1_ready, 0);
                sbq.push_back(predict(who, a, b, acc_edge));
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int e0;
        int edges[3];
        int cnt;
        bit order[4];
        logic [W-1:0] ra, rb;
        bit who;

        // Reset state, with both requesters already asking.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_results", {res_valid, res_id, res_lt, res_eq, res_gt}, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;

        // Equal operands, full-width scan.
        issue(0, 6'h2A, 6'h2A, e0);
        wait_idle();

        // Decision on the MSB; busy clears two edges after accept.
        issue(1, 6'h20, 6'h1F, e0);
        @(negedge clk);
        chk("busy_scan", busy, 1);
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("cyc_busy_edge", cyc, e0 + 2);
        wait_idle();

        // Low-bit decision; operands scrambled during SCAN must not matter.
        issue(0, 6'h05, 6'h07, e0);
        req0_a = 6'h3F;
        req0_b = 6'h3F;
        wait_idle();

        // Contention from reset: 0,1,0,1.
        do_reset();
        order = '{0, 1, 0, 1};
        req0_a = 6'h03; req0_b = 6'h09;
        req1_a = 6'h09; req1_b = 6'h03;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        cnt = 0;
        for (int n = 0; n < 100 && cnt < 4; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("grant_order", req1_ready, order[cnt]);
                chk("ready_both", req0_ready & req1_ready, 0);
                sbq.push_back(predict(order[cnt], order[cnt] ? req1_a : req0_a,
                                      order[cnt] ? req1_b : req0_b, cyc + 1));
                cnt++;
            end
        end
        chk("grant_count", cnt, 4);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();

        // Reset on the third SCAN cycle aborts the compare.
        issue(0, 6'h00, 6'h00, e0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        req0_valid = 1'b1;
        req0_a = 6'h11;
        req0_b = 6'h22;
        @(negedge clk);
        chk("abort_ready_in_reset", req0_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_results", {res_valid, res_id, res_lt, res_eq, res_gt}, 0);
        chk("abort_ready_first", req0_ready, 1);
        if (req0_ready) sbq.push_back(predict(0, 6'h11, 6'h22, cyc + 1));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_idle();

        // Back-to-back: 3F vs 3E gives k=6, period 8.
        @(posedge clk);
        #1;
        req0_a = 6'h3F;
        req0_b = 6'h3E;
        req0_valid = 1'b1;
        cnt = 0;
        for (int n = 0; n < 60 && cnt < 3; n++) begin
            @(negedge clk);
            if (req0_ready) begin
                edges[cnt] = cyc + 1;
                sbq.push_back(predict(0, 6'h3F, 6'h3E, cyc + 1));
                cnt++;
            end
        end
        chk("b2b_count", cnt, 3);
        if (cnt == 3) begin
            chk("b2b_period_1", edges[1] - edges[0], 8);
            chk("b2b_period_2", edges[2] - edges[1], 8);
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        wait_idle();

        // Random single-requester traffic.
        for (int t = 0; t < 10; t++) begin
            who = 1'($urandom_range(0, 1));
            ra  = W'($urandom_range(0, (1 << W) - 1));
            rb  = (t % 3 == 0) ? ra : W'($urandom_range(0, (1 << W) - 1));
            issue(who, ra, rb, e0);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
